// File: rtl/hs_pkg.sv
// Shared definitions for the two-input round-robin handshake merge controller.
//   - hs_state_e      : arbiter FSM states (2-bit encoding)
//   - req_idx_t       : index of a requester (0 or 1)
//   - SYNC_STAGES_MIN : shallowest synchroniser that still guards against metastability
`timescale 1ns/1ps
package hs_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        REQ      = 2'd2,
        WAIT_ACK = 2'd3
    } hs_state_e;

    typedef logic req_idx_t;

endpackage

// File: rtl/hs_rr_merge_ctrl_if.sv
// Bundle of every handshake/data signal around the merge controller.
//   io_In0_* / io_In1_* : two bundled-data 2-phase producer channels
//   io_Out_*            : merged 2-phase consumer channel
//   io_Grant, io_Busy   : status
// Modports:
//   master : the merge controller itself
//   slave  : the surrounding environment (producers + consumer)
`timescale 1ns/1ps
interface hs_rr_merge_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              io_In0_HS_Req;
    logic              io_In0_HS_Ack;
    logic [DATA_W-1:0] io_In0_Data;
    logic              io_In1_HS_Req;
    logic              io_In1_HS_Ack;
    logic [DATA_W-1:0] io_In1_Data;
    logic              io_Out_HS_Req;
    logic              io_Out_HS_Ack;
    logic [DATA_W-1:0] io_Out_Data;
    logic              io_Grant;
    logic              io_Busy;

    modport master (
        input  io_In0_HS_Req, io_In0_Data,
        input  io_In1_HS_Req, io_In1_Data,
        input  io_Out_HS_Ack,
        output io_In0_HS_Ack, io_In1_HS_Ack,
        output io_Out_HS_Req, io_Out_Data,
        output io_Grant, io_Busy
    );

    modport slave (
        output io_In0_HS_Req, io_In0_Data,
        output io_In1_HS_Req, io_In1_Data,
        output io_Out_HS_Ack,
        input  io_In0_HS_Ack, io_In1_HS_Ack,
        input  io_Out_HS_Req, io_Out_Data,
        input  io_Grant, io_Busy
    );
endinterface

// File: rtl/hs_sync.sv
// N-stage bit synchroniser, all flops cleared by the synchronous reset.
// Ports:
//   clock, reset : destination clock and synchronous active-high reset
//   d            : asynchronous input level
//   q            : synchronised level, SYNC_STAGES clocks behind d
// Depths below SYNC_STAGES_MIN are raised to SYNC_STAGES_MIN.
`timescale 1ns/1ps
module hs_sync
    import hs_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    localparam int DEPTH = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clock) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], d};
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/hs_rr_merge_ctrl.sv
// Round-robin merge of two asynchronous 2-phase bundled-data producers onto one
// 2-phase output channel.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   bus          : hs_rr_merge_ctrl_if.master (producer req/ack/data, merged
//                  output req/ack/data, io_Grant, io_Busy)
// A token is accepted from one requester at a time: its data is registered,
// the output request toggles one cycle later, and the requester's ack toggles
// once the consumer has acknowledged the output token.
`timescale 1ns/1ps
module hs_rr_merge_ctrl
    import hs_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    hs_rr_merge_ctrl_if.master    bus
);

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_LOAD     = LOAD;
    localparam logic [1:0] S_REQ      = REQ;
    localparam logic [1:0] S_WAIT_ACK = WAIT_ACK;

    logic              req0_s;
    logic              req1_s;
    logic              out_ack_s;

    logic [1:0]        state_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              out_req_q;
    logic [DATA_W-1:0] out_data_q;
    req_idx_t          grant_q;
    req_idx_t          rr_ptr_q;

    logic              pend0;
    logic              pend1;
    logic              out_pend;
    req_idx_t          pick;

    hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req0 (
        .clock (clock),
        .reset (reset),
        .d     (bus.io_In0_HS_Req),
        .q     (req0_s)
    );

    hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req1 (
        .clock (clock),
        .reset (reset),
        .d     (bus.io_In1_HS_Req),
        .q     (req1_s)
    );

    hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_out_ack (
        .clock (clock),
        .reset (reset),
        .d     (bus.io_Out_HS_Ack),
        .q     (out_ack_s)
    );

    // 2-phase: a channel holds a token whenever its req and ack levels differ.
    assign pend0    = req0_s ^ ack0_q;
    assign pend1    = req1_s ^ ack1_q;
    assign out_pend = out_req_q ^ out_ack_s;

    // A lone pending input wins outright; a tie goes to the round-robin pointer.
    assign pick = (pend0 && pend1) ? rr_ptr_q : pend1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            grant_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pend0 || pend1) begin
                        out_data_q <= pick ? bus.io_In1_Data : bus.io_In0_Data;
                        grant_q    <= pick;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Data was registered on the previous edge, so the request
                    // edge launched here trails it by a full cycle of setup.
                    out_req_q <= ~out_req_q;
                    state_q   <= S_REQ;
                end
                S_REQ: begin
                    state_q <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!out_pend) begin
                        if (grant_q) begin
                            ack1_q <= ~ack1_q;
                        end else begin
                            ack0_q <= ~ack0_q;
                        end
                        rr_ptr_q <= ~grant_q;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.io_In0_HS_Ack = ack0_q;
    assign bus.io_In1_HS_Ack = ack1_q;
    assign bus.io_Out_HS_Req = out_req_q;
    assign bus.io_Out_Data   = out_data_q;
    assign bus.io_Grant      = grant_q;
    assign bus.io_Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_hs_rr_merge_ctrl.sv
// Self-checking bench for hs_rr_merge_ctrl: directed steps with random data,
// checked against a queue-based model of the round-robin token ordering.
`timescale 1ns/1ps
module tb_hs_rr_merge_ctrl;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    hs_rr_merge_ctrl_if #(.DATA_W(DATA_W)) bus ();

    hs_rr_merge_ctrl #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Environment-side drive variables
    logic              req0 = 1'b0;
    logic              req1 = 1'b0;
    logic [DATA_W-1:0] data0 = '0;
    logic [DATA_W-1:0] data1 = '0;
    logic              cons_ack = 1'b0;
    logic              auto_ack = 1'b0;
    logic              ack_ovr_en = 1'b0;
    logic              ack_ovr_val = 1'b0;

    assign bus.io_In0_HS_Req = req0;
    assign bus.io_In1_HS_Req = req1;
    assign bus.io_In0_Data   = data0;
    assign bus.io_In1_Data   = data1;
    assign bus.io_Out_HS_Ack = ack_ovr_en ? ack_ovr_val : cons_ack;

    int total = 0;
    int bad   = 0;

    // Consumer: acknowledges each output request edge 5 ns later.
    always @(bus.io_Out_HS_Req) begin
        if (auto_ack) begin
            #5;
            cons_ack = bus.io_Out_HS_Req;
        end
    end

    // Observed output tokens (one per request edge outside reset).
    logic [DATA_W-1:0] tok_d[$];
    logic              tok_g[$];
    logic              last_req = 1'b0;

    always @(posedge clock) begin
        #2;
        if (reset) begin
            last_req = bus.io_Out_HS_Req;
        end else if (bus.io_Out_HS_Req !== last_req) begin
            tok_d.push_back(bus.io_Out_Data);
            tok_g.push_back(bus.io_Grant);
            last_req = bus.io_Out_HS_Req;
        end
    end

    // Reference model: per-requester FIFOs of offered tokens, drained with
    // "tie goes to the pointer, pointer moves past the winner".
    logic [DATA_W-1:0] m_q0[$];
    logic [DATA_W-1:0] m_q1[$];
    logic [DATA_W-1:0] m_out_d[$];
    logic              m_out_g[$];
    logic              m_ptr = 1'b0;

    task automatic model_run();
        logic g;
        m_out_d.delete();
        m_out_g.delete();
        while (m_q0.size() > 0 || m_q1.size() > 0) begin
            if (m_q0.size() > 0 && m_q1.size() > 0) g = m_ptr;
            else g = (m_q1.size() > 0);
            if (g) m_out_d.push_back(m_q1.pop_front());
            else   m_out_d.push_back(m_q0.pop_front());
            m_out_g.push_back(g);
            m_ptr = ~g;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] out_vec();
        return {19'd0, bus.io_In0_HS_Ack, bus.io_In1_HS_Ack, bus.io_Out_HS_Req,
                bus.io_Grant, bus.io_Busy, bus.io_Out_Data};
    endfunction

    task automatic cmp_tokens(input string tag);
        check({tag, "_count"}, tok_d.size(), m_out_d.size());
        for (int i = 0; i < tok_d.size() && i < m_out_d.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), tok_d[i], m_out_d[i]);
            check($sformatf("%s_grant%0d", tag, i), tok_g[i], m_out_g[i]);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clock);
            #1;
            if (!bus.io_Busy && bus.io_In0_HS_Ack == req0 && bus.io_In1_HS_Ack == req1 &&
                bus.io_Out_HS_Req == bus.io_Out_HS_Ack) begin
                done = 1;
                break;
            end
        end
        check({tag, "_idle"}, done, 1);
    endtask

    task automatic put0(input logic [DATA_W-1:0] d);
        bit ok = 0;
        for (int k = 0; k < 400; k++) begin
            if (bus.io_In0_HS_Ack == req0) begin ok = 1; break; end
            @(negedge clock);
        end
        check("put0_ready", ok, 1);
        if (ok) begin
            data0 = d;
            #1;
            req0 = ~req0;
        end
    endtask

    task automatic put1(input logic [DATA_W-1:0] d);
        bit ok = 0;
        for (int k = 0; k < 400; k++) begin
            if (bus.io_In1_HS_Ack == req1) begin ok = 1; break; end
            @(negedge clock);
        end
        check("put1_ready", ok, 1);
        if (ok) begin
            data1 = d;
            #1;
            req1 = ~req1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = '0;
        data1 = '0;
        m_ptr = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] fa, fb, ft;
        logic [DATA_W-1:0] r0[$];
        logic [DATA_W-1:0] r1[$];

        // Step 1: reset with random input levels
        reset       = 1'b1;
        req0        = 1'($urandom);
        req1        = 1'($urandom);
        data0       = DATA_W'($urandom);
        data1       = DATA_W'($urandom);
        ack_ovr_en  = 1'b1;
        ack_ovr_val = 1'($urandom);
        for (int c = 0; c < 3; c++) begin
            tick(1);
            check($sformatf("reset_outs%0d", c), out_vec(), 0);
        end
        req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        ack_ovr_val = 1'b0;
        tick(1);
        ack_ovr_en = 1'b0;
        auto_ack   = 1'b1;
        reset      = 1'b0;
        tick(1);
        check("post_reset_outs", out_vec(), 0);

        // Step 2: single token on In0, latency of both edges
        data0 = 8'h05;
        req0  = 1'b1;
        tick(SYNC_STAGES + 1);
        check("lat_req_early", bus.io_Out_HS_Req, 0);
        tick(1);
        check("lat_req_edge", bus.io_Out_HS_Req, 1);
        check("single_data", bus.io_Out_Data, 8'h05);
        check("single_grant", bus.io_Grant, 0);
        check("single_busy", bus.io_Busy, 1);
        tick(SYNC_STAGES);
        check("lat_ack_early", bus.io_In0_HS_Ack, 0);
        tick(1);
        check("lat_ack_edge", bus.io_In0_HS_Ack, 1);
        wait_idle("single");

        // Step 3: simultaneous requests right after reset
        do_reset();
        tok_d.delete(); tok_g.delete();
        data0 = 8'h0D; data1 = 8'h15;
        req0 = 1'b1;   req1 = 1'b1;
        m_q0.push_back(8'h0D);
        m_q1.push_back(8'h15);
        model_run();
        wait_idle("simul");
        cmp_tokens("simul");
        check("simul_out_req", bus.io_Out_HS_Req, 0);
        check("simul_ack0", bus.io_In0_HS_Ack, 1);
        check("simul_ack1", bus.io_In1_HS_Ack, 1);

        // Step 4: both requesters saturated, random data
        tok_d.delete(); tok_g.delete();
        r0.delete(); r1.delete();
        for (int i = 0; i < 4; i++) begin
            r0.push_back(DATA_W'($urandom));
            r1.push_back(DATA_W'($urandom));
            m_q0.push_back(r0[i]);
            m_q1.push_back(r1[i]);
        end
        model_run();
        @(negedge clock);
        fork
            for (int i = 0; i < 4; i++) put0(r0[i]);
            for (int i = 0; i < 4; i++) put1(r1[i]);
        join
        wait_idle("sat");
        cmp_tokens("sat");

        // Step 5: reset during WAIT_ACK, then a late output ack
        auto_ack = 1'b0;
        data0 = DATA_W'($urandom);
        req0  = ~req0;
        begin
            bit seen = 0;
            for (int k = 0; k < 20; k++) begin
                tick(1);
                if (bus.io_Out_HS_Req != cons_ack) begin seen = 1; break; end
            end
            check("abort_req_seen", seen, 1);
        end
        tick(2);
        check("abort_busy_before", bus.io_Busy, 1);
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        tick(1);
        check("abort_reset_outs", out_vec(), 0);
        tick(1);
        check("abort_reset_hold", out_vec(), 0);
        reset = 1'b0;
        ack_ovr_en  = 1'b1;
        ack_ovr_val = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            check($sformatf("late_ack_outs%0d", c), out_vec(), 0);
        end
        reset = 1'b1;
        ack_ovr_val = 1'b0;
        tick(2);
        ack_ovr_en = 1'b0;
        auto_ack   = 1'b1;
        do_reset();

        // Step 6: Fibonacci producer on In0, In1 idle
        tok_d.delete(); tok_g.delete();
        fa = 8'd1; fb = 8'd1;
        for (int i = 0; i < 8; i++) begin
            m_q0.push_back(fa);
            ft = fa + fb; fa = fb; fb = ft;
        end
        model_run();
        @(negedge clock);
        fa = 8'd1; fb = 8'd1;
        for (int i = 0; i < 8; i++) begin
            put0(fa);
            ft = fa + fb; fa = fb; fb = ft;
        end
        wait_idle("fib");
        cmp_tokens("fib");

        // Step 7: random gaps on both producers; per-source order must hold
        tok_d.delete(); tok_g.delete();
        r0.delete(); r1.delete();
        for (int i = 0; i < 6; i++) begin
            r0.push_back(DATA_W'($urandom));
            r1.push_back(DATA_W'($urandom));
        end
        @(negedge clock);
        fork
            for (int i = 0; i < 6; i++) begin
                repeat ($urandom_range(0, 12)) @(negedge clock);
                put0(r0[i]);
            end
            for (int i = 0; i < 6; i++) begin
                repeat ($urandom_range(0, 12)) @(negedge clock);
                put1(r1[i]);
            end
        join
        wait_idle("rand");
        check("rand_count", tok_d.size(), 12);
        begin
            int n0 = 0;
            int n1 = 0;
            for (int i = 0; i < tok_d.size(); i++) begin
                if (tok_g[i] == 1'b0) begin
                    if (n0 < 6) check($sformatf("rand_src0_%0d", n0), tok_d[i], r0[n0]);
                    n0++;
                end else begin
                    if (n1 < 6) check($sformatf("rand_src1_%0d", n1), tok_d[i], r1[n1]);
                    n1++;
                end
            end
            check("rand_n0", n0, 6);
            check("rand_n1", n1, 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hs_rr_merge_ctrl.md
Name: hs_rr_merge_ctrl

Overview:
Clocked round-robin arbiter that shares one bundled-data 2-phase handshake output channel between two asynchronous producers, e.g. two Fibonacci_main instances.
Incoming requests and the output acknowledge are synchronised into the clock domain.
One requester is granted at a time; its data is registered, forwarded with a request transition, and the requester is acknowledged once the consumer acknowledges.
Sits between the self-timed generators and a single downstream consumer or clocked sink.

Parameters:
DATA_W, 8, width of the data bus on every channel
SYNC_STAGES, 2, flip-flop depth of each req/ack synchroniser (minimum 2)

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
io_In0_HS_Req  input  1  requester 0 request, 2-phase (each transition = one token)
io_In0_HS_Ack  output  1  requester 0 acknowledge, 2-phase
io_In0_Data  input  DATA_W  requester 0 bundled data; stable while In0 is pending
io_In1_HS_Req  input  1  requester 1 request
io_In1_HS_Ack  output  1  requester 1 acknowledge
io_In1_Data  input  DATA_W  requester 1 bundled data
io_Out_HS_Req  output  1  merged-channel request, 2-phase
io_Out_HS_Ack  input  1  merged-channel acknowledge, 2-phase
io_Out_Data  output  DATA_W  merged-channel data, registered
io_Grant  output  1  index of the requester currently or last granted
io_Busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values, applied one cycle after reset is sampled high:
  - all synchroniser flops = 0
  - io_In0_HS_Ack = io_In1_HS_Ack = io_Out_HS_Req = 0
  - io_Out_Data = 0, io_Grant = 0, io_Busy = 0
  - rr_ptr = 0 (In0 favoured), state = IDLE
- Pending conditions:
  - input i pending when sync(Req_i) != Ack_i
  - output pending when io_Out_HS_Req != sync(io_Out_HS_Ack)
- FSM, IDLE:
  - if no input is pending, stay in IDLE
  - if exactly one input is pending, grant it
  - if both are pending, grant rr_ptr
  - on grant: io_Out_Data <= Data_g, io_Grant <= g, go to LOAD
- FSM, LOAD: wait one cycle so data is stable before the request edge (bundled-data setup); go to REQ.
- FSM, REQ: io_Out_HS_Req toggles; go to WAIT_ACK.
- FSM, WAIT_ACK:
  - wait until the output is no longer pending
  - then toggle Ack_g, set rr_ptr <= ~g, go to IDLE
  - Pending_g clears in the same cycle, so it is never re-granted spuriously.
- Latency:
  - input Req edge to io_Out_HS_Req edge = SYNC_STAGES + 2 clocks
  - output Ack edge to input Ack edge = SYNC_STAGES + 1 clocks
- io_Out_Data changes only in IDLE on grant, never while the output is pending.
- Fairness: with both inputs continuously pending, grants strictly alternate; no starvation.
- Simultaneous new requests in the same cycle: resolved by rr_ptr, which is 0 after reset.
- A request arriving while WAIT_ACK is active stays pending and is serviced on the next IDLE cycle.
- An io_Out_HS_Ack transition while the output is not pending is a protocol violation: it is ignored, no state change, no assertion fired in RTL.
- Reset mid-transaction (any state): everything returns to reset values and the in-flight token is abandoned. The environment is required to return all its req/ack lines to 0 under the same reset.
- DATA_W passes through without modification; there is no arithmetic in the datapath.

Decomposition:
- Shared package (hs_pkg):
  - FSM state enum: IDLE, LOAD, REQ, WAIT_ACK, 2-bit encoding
  - requester index type
  - constant SYNC_STAGES_MIN = 2
- Sub-module hs_sync: N-stage reset-to-0 bit synchroniser, parameter SYNC_STAGES.
  - instantiated 3 times: In0 Req, In1 Req, Out Ack

Test Plan:
1. Reset held 3 cycles with random input levels -> all outputs 0, io_Busy 0, and they stay 0 while reset is high.
2. In0: Data 0x05, Req 0->1; Out Ack = Req delayed 5 ns -> io_Out_Data 0x05 and io_Out_HS_Req 1 at SYNC_STAGES+2 clocks; io_Grant 0; io_In0_HS_Ack 1 at SYNC_STAGES+1 clocks after the Out Ack edge.
3. In0 (0x0D) and In1 (0x15) toggle in the same cycle -> output tokens 0x0D (grant 0) then 0x15 (grant 1); io_Out_HS_Req ends at 0 after two transitions; both acks end at 1.
4. Both requesters saturated, 4 tokens each -> 8 output tokens with io_Grant sequence 0,1,0,1,0,1,0,1 and no token lost or duplicated.
5. Reset pulsed during WAIT_ACK, then a late Out Ack edge -> reset values next cycle; the late ack is ignored and io_Busy stays 0.
6. In0 driven by Fibonacci_main with Go=1, In1 idle -> io_Out_Data sequence 1,1,2,3,5,8,13,21, each value exactly once and in order.
